// File: rtl/rrf_commit_map.sv
// rrf_commit_map: retirement register file holding the committed
// architectural-to-physical map. Applies up to ID_WIDTH retiring lanes per
// cycle, in lane order, and returns each superseded physical register to the
// free list one cycle later. On a backend flush, a one-cycle restore_valid
// pulse tells the rename table to copy restore_map.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   commit_valid    per-lane retire strobe (lane 0 oldest)
//   commit_rd_phy   per-lane new physical destination
//   commit_rd_arch  per-lane architectural destination
//   backend_flush   mispredict flush, same cycle as the branch retires
//   fl_push_valid   per-lane free-list return strobe (registered)
//   fl_push_phy     per-lane freed physical register (registered)
//   restore_valid   one-cycle pulse the cycle after backend_flush
//   restore_map     committed map, entry a at [a*PRF_IDX +: PRF_IDX]
//
// Optional: define RRF_PERF_CNT_EN to add perf_retire_cnt (64b, retired
// lanes including x0 writes) and perf_flush_cnt (32b, flush cycles).
module rrf_commit_map #(
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned ARF_DEPTH = 32,
  parameter int unsigned ARF_IDX   = 5,
  parameter int unsigned PRF_DEPTH = 64,
  parameter int unsigned PRF_IDX   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ID_WIDTH-1:0]           commit_valid,
  input  logic [ID_WIDTH*PRF_IDX-1:0]   commit_rd_phy,
  input  logic [ID_WIDTH*ARF_IDX-1:0]   commit_rd_arch,
  input  logic                          backend_flush,
  output logic [ID_WIDTH-1:0]           fl_push_valid,
  output logic [ID_WIDTH*PRF_IDX-1:0]   fl_push_phy,
  output logic                          restore_valid,
  output logic [ARF_DEPTH*PRF_IDX-1:0]  restore_map
`ifdef RRF_PERF_CNT_EN
  ,
  output logic [63:0]                   perf_retire_cnt,
  output logic [31:0]                   perf_flush_cnt
`endif
);

  localparam int unsigned RETIRE_CNT_W = 64;
  localparam int unsigned FLUSH_CNT_W  = 32;

  logic [PRF_IDX-1:0] map_q [ARF_DEPTH];
  logic [PRF_IDX-1:0] map_d [ARF_DEPTH];

  logic [ID_WIDTH-1:0]         push_valid_d;
  logic [ID_WIDTH*PRF_IDX-1:0] push_phy_d;
  logic [ARF_IDX-1:0]          lane_arch;
  logic [PRF_IDX-1:0]          lane_phy;

  // Sequential lane walk: each lane sees the map as updated by older lanes,
  // so a same-bundle collision frees the older lane's new physical register.
  always_comb begin
    map_d        = map_q;
    push_valid_d = '0;
    push_phy_d   = fl_push_phy;
    lane_arch    = '0;
    lane_phy     = '0;
    for (int i = 0; i < ID_WIDTH; i++) begin
      lane_arch = commit_rd_arch[i*ARF_IDX +: ARF_IDX];
      lane_phy  = commit_rd_phy[i*PRF_IDX +: PRF_IDX];
      if (commit_valid[i] && (lane_arch != '0)) begin
        push_valid_d[i]                   = 1'b1;
        push_phy_d[i*PRF_IDX +: PRF_IDX]  = map_d[lane_arch];
        map_d[lane_arch]                  = lane_phy;
      end
    end
  end

  // Map and free-list registers; reset restores the identity map.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < ARF_DEPTH; a++) begin
        map_q[a] <= PRF_IDX'(a);
      end
      fl_push_valid <= '0;
      fl_push_phy   <= '0;
      restore_valid <= 1'b0;
    end else begin
      map_q         <= map_d;
      fl_push_valid <= push_valid_d;
      fl_push_phy   <= push_phy_d;
      restore_valid <= backend_flush;
    end
  end

  // Committed map is exported flat every cycle.
  always_comb begin
    restore_map = '0;
    for (int a = 0; a < ARF_DEPTH; a++) begin
      restore_map[a*PRF_IDX +: PRF_IDX] = map_q[a];
    end
  end

`ifdef RRF_PERF_CNT_EN
  logic [RETIRE_CNT_W-1:0] retire_inc;

  // Counts every retiring lane, x0 writes included.
  always_comb begin
    retire_inc = '0;
    for (int i = 0; i < ID_WIDTH; i++) begin
      retire_inc = retire_inc + RETIRE_CNT_W'(commit_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retire_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      perf_retire_cnt <= perf_retire_cnt + retire_inc;
      perf_flush_cnt  <= perf_flush_cnt + FLUSH_CNT_W'(backend_flush);
    end
  end
`endif

endmodule
